// File: rtl/mips_register_file.sv
// 32-entry MIPS general-purpose register file: two combinational read ports,
// one synchronous write port, hardwired r0, optional write-to-read bypass.
module mips_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit BYPASS_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rd_addr0,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    output logic [DATA_WIDTH-1:0] rd_data0,
    output logic [DATA_WIDTH-1:0] rd_data1,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [7:0]            wr_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_commit;

    assign wr_commit = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_count <= '0;
        end else if (wr_commit) begin
            mem[wr_addr] <= wr_data;
            if (wr_count != 8'hFF) begin
                wr_count <= wr_count + 8'd1;
            end
        end
    end

    // Bypass is gated by rst_n so reads stay zero while reset is held,
    // even if a write is still being presented.
    always_comb begin
        rd_data0 = '0;
        rd_data1 = '0;
        if (rd_addr0 != '0) begin
            if (BYPASS_EN && rst_n && wr_commit && (wr_addr == rd_addr0)) begin
                rd_data0 = wr_data;
            end else begin
                rd_data0 = mem[rd_addr0];
            end
        end
        if (rd_addr1 != '0) begin
            if (BYPASS_EN && rst_n && wr_commit && (wr_addr == rd_addr1)) begin
                rd_data1 = wr_data;
            end else begin
                rd_data1 = mem[rd_addr1];
            end
        end
    end

endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file: a bypassing and a non-bypassing
// instance share stimulus; vector table plus reset and saturation sequences.
module tb_mips_register_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rd_addr0, rd_addr1, wr_addr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data0_b, rd_data1_b, rd_data0_n, rd_data1_n;
    logic [7:0]  wr_count_b, wr_count_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_data0(rd_data0_b), .rd_data1(rd_data1_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_count(wr_count_b)
    );

    mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_data0(rd_data0_n), .rd_data1(rd_data1_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_count(wr_count_n)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] pre0;   // bypassing instance, before the edge
        logic [31:0] pre1;
        logic [31:0] npre0;  // non-bypassing instance, before the edge
        logic [31:0] npre1;
        logic [31:0] post0;  // both instances, after the edge
        logic [31:0] post1;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rd_addr0 = ra0;
        rd_addr1 = ra1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd12, 32'hDEADBEEF, 5'd12, 5'd6,
                    32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 8'd1};
        vecs[1] = '{1'b1, 5'd6, 32'h00000006, 5'd12, 5'd6,
                    32'hDEADBEEF, 32'h6, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h6, 8'd2};
        vecs[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd12,
                    32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 8'd2};
        vecs[3] = '{1'b1, 5'd6, 32'h12345678, 5'd6, 5'd6,
                    32'h12345678, 32'h12345678, 32'h6, 32'h6, 32'h12345678, 32'h12345678, 8'd3};
        vecs[4] = '{1'b0, 5'd12, 32'h0, 5'd12, 5'd6,
                    32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678,
                    32'hDEADBEEF, 32'h12345678, 8'd3};
        vecs[5] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd0,
                    32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 32'hA5A5A5A5, 32'h0, 8'd4};
        vecs[6] = '{1'b0, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd1,
                    32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 32'h0, 8'd4};

        // Reset asserted mid-cycle, no clock edge needed.
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd12);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rd0_a0",  rd_data0_b, 32'h0);
        chk("rst_rd1_a12", rd_data1_b, 32'h0);
        rd_addr0 = 5'd31;
        #1;
        chk("rst_rd0_a31", rd_data0_b, 32'h0);
        chk("rst_cnt",     {24'h0, wr_count_b}, 32'h0);
        chk("rst_cnt_nb",  {24'h0, wr_count_n}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra0, vecs[i].ra1);
            #1;
            chk($sformatf("v%0d_pre0", i),    rd_data0_b, vecs[i].pre0);
            chk($sformatf("v%0d_pre1", i),    rd_data1_b, vecs[i].pre1);
            chk($sformatf("v%0d_nb_pre0", i), rd_data0_n, vecs[i].npre0);
            chk($sformatf("v%0d_nb_pre1", i), rd_data1_n, vecs[i].npre1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_post0", i),    rd_data0_b, vecs[i].post0);
            chk($sformatf("v%0d_post1", i),    rd_data1_b, vecs[i].post1);
            chk($sformatf("v%0d_nb_post0", i), rd_data0_n, vecs[i].post0);
            chk($sformatf("v%0d_nb_post1", i), rd_data1_n, vecs[i].post1);
            chk($sformatf("v%0d_cnt", i),      {24'h0, wr_count_b}, {24'h0, vecs[i].cnt});
            chk($sformatf("v%0d_nb_cnt", i),   {24'h0, wr_count_n}, {24'h0, vecs[i].cnt});
        end

        // Async reset pulse between edges while a write to 31 is pending.
        @(negedge clk);
        drive(1'b1, 5'd31, 32'h11111111, 5'd31, 5'd12);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_rd0",    rd_data0_b, 32'h0);
        chk("mid_rst_rd1",    rd_data1_b, 32'h0);
        chk("mid_rst_nb_rd0", rd_data0_n, 32'h0);
        chk("mid_rst_cnt",    {24'h0, wr_count_b}, 32'h0);
        #1 rst_n = 1'b1;
        wr_en = 1'b0;
        #1;
        chk("post_rst_rd0",    rd_data0_b, 32'h0);
        chk("post_rst_nb_rd0", rd_data0_n, 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_edge_rd0", rd_data0_b, 32'h0);
        chk("post_rst_edge_cnt", {24'h0, wr_count_b}, 32'h0);

        // First write after reset commits on the first edge.
        @(negedge clk);
        drive(1'b1, 5'd12, 32'h00000077, 5'd12, 5'd31);
        @(posedge clk);
        #1;
        chk("first_wr_nb_rd0", rd_data0_n, 32'h00000077);
        chk("first_wr_cnt",    {24'h0, wr_count_n}, 32'h1);

        // Saturation: 300 further writes to addr 1.
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            drive(1'b1, 5'd1, i, 5'd1, 5'd12);
            @(posedge clk);
            #1;
            if (i == 253) begin
                chk("cnt_254", {24'h0, wr_count_b}, 32'd254);
            end
            if (i == 254) begin
                chk("cnt_255", {24'h0, wr_count_b}, 32'd255);
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        chk("sat_cnt",      {24'h0, wr_count_b}, 32'd255);
        chk("sat_cnt_nb",   {24'h0, wr_count_n}, 32'd255);
        chk("sat_last_val", rd_data0_b, 32'd300);
        chk("sat_last_nb",  rd_data0_n, 32'd300);
        chk("sat_keep_12",  rd_data1_n, 32'h00000077);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_register_file.md
Name: mips_register_file

Overview:
- 32-entry general-purpose register file for the single-cycle/pipelined MIPS datapath.
- Sits directly downstream of the 5-bit write-destination mux (rt/rd select). That mux's 5-bit output drives wr_addr here.
- Provides two combinational read ports (rs, rt) and one synchronous write port.
- Register 0 is hardwired to zero. Same-cycle write-to-read bypass is included so decode sees writeback data.

Parameters:
- DATA_WIDTH, 32, width of each register and data port
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH (32 entries)
- BYPASS_EN, 1, 1 = forward write data to read ports on address match; 0 = read returns stored value only

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-low
- rd_addr0  input  ADDR_WIDTH  read port 0 address (rs)
- rd_addr1  input  ADDR_WIDTH  read port 1 address (rt)
- rd_data0  output  DATA_WIDTH  read port 0 data
- rd_data1  output  DATA_WIDTH  read port 1 data
- wr_en  input  1  write enable, sampled on rising clk
- wr_addr  input  ADDR_WIDTH  write address, from the 5-bit destination mux
- wr_data  input  DATA_WIDTH  write data
- wr_count  output  8  saturating count of committed writes (debug/verification aid)

Behaviour:
- Reset: rst_n low asynchronously clears all 32 registers to 0 and wr_count to 0, independent of clk.
  - Read outputs are combinational, so they read 0 during reset.
  - Writes are ignored while rst_n is low.
  - After deassertion, the first write can commit on the first rising clk edge with rst_n high.
- Write: on rising clk with rst_n=1, wr_en=1 and wr_addr!=0, mem[wr_addr] <= wr_data and wr_count increments.
  - wr_count saturates at 255 and never wraps.
  - wr_addr=0 with wr_en=1 is discarded: mem[0] stays 0 and wr_count does not increment.
  - wr_en=0 leaves all state unchanged.
- Read: rd_dataN = mem[rd_addrN], combinational, zero cycle latency.
  - rd_addrN=0 always yields 0, regardless of bypass.
- Bypass (BYPASS_EN=1): if wr_en=1 and wr_addr!=0 and wr_addr==rd_addrN, rd_dataN = wr_data in the same cycle, before the edge.
  - Both ports may bypass at once.
  - With BYPASS_EN=0, the new value is visible only after the edge.
- Simultaneous events:
  - Both read ports may address the same register.
  - A read and write to the same register in one cycle follows the bypass rule.
  - Only one write per cycle. No write conflicts are possible.
- Width rules:
  - Full-width stores, no sign handling.
  - wr_addr is used unmodified; all 32 values are legal.
- Reset mid-operation: a write whose edge coincides with rst_n low is lost. Registers read 0 until rewritten.

Test Plan:
- Reset then read: assert rst_n=0 mid-cycle (no clk edge) -> rd_data0/rd_data1 = 0 immediately for addresses 0, 12, 31; wr_count=0.
- Write/read addr 12 and 6:
  - Write 32'hDEADBEEF to addr 5'b01100, then 32'h00000006 to addr 5'b00110.
  - Set rd_addr0=12, rd_addr1=6 -> rd_data0=32'hDEADBEEF, rd_data1=32'h00000006; wr_count=2.
- Register zero:
  - wr_en=1, wr_addr=0, wr_data=32'hFFFFFFFF, one edge -> rd_data0 at addr 0 = 0; wr_count unchanged.
- Bypass:
  - BYPASS_EN=1, mem[6]=6.
  - Drive wr_en=1, wr_addr=6, wr_data=32'h12345678, rd_addr0=rd_addr1=6 before the edge -> both read 32'h12345678 pre-edge.
  - Repeat with BYPASS_EN=0 -> read 6 pre-edge, 32'h12345678 post-edge.
- Async reset mid-write:
  - Fill addr 31 with 32'hA5A5A5A5.
  - Pulse rst_n low between edges while wr_en=1, wr_addr=31 -> addr 31 reads 0; wr_count=0.
- Saturation: 300 consecutive writes to addr 1 -> wr_count=255; addr 1 holds the last value written.
